pixel_scheduler: RTL and testbench
==================================

Name: pixel_scheduler

Overview:
- Frame-level controller that sequences the parameter-fetch stage and the bank of LANES Mandelbrot (MBT) iteration cores.
- Walks the screen in row-major order, LANES horizontally adjacent pixels per tile.
- For each tile it drives i_x/i_y to the fetch stage, pulses reset then start to the cores, and waits for every lane to finish.
- Finished iteration counts are serialised into frame-buffer write transactions.

Parameters:
- H_RES, 800, pixels per row; must be a multiple of LANES.
- V_RES, 600, rows per frame.
- LANES, 4, MBT cores served in parallel (pixels per tile).
- SETTLE_CYC, 2, cycles between rstMBT deassertion and start; covers the fetch-stage pipeline latency.
- ITER_W, 8, width of one iteration count.
- ADDR_W, 19, frame-buffer address width; must hold H_RES*V_RES-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- zoom_in  in  2  requested zoom level; sampled with frame_start.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last write of a frame.
- i_x  out  16  pixel column of lane 0 of the current tile; integer, unsigned.
- i_y  out  16  pixel row of the current tile.
- zoom_level  out  2  zoom level latched for the current frame.
- rstMBT  out  1  active-high core reset pulse, sent to the fetch stage.
- start  out  1  one-cycle core start pulse, sent to the fetch stage.
- mbt_done  in  LANES  per-lane completion level/pulse; bit k from core k.
- mbt_iter  in  LANES*ITER_W  per-lane iteration counts; lane k at [k*ITER_W +: ITER_W].
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  linear pixel address, y*H_RES + x.
- wr_data  out  ITER_W  iteration count for wr_addr.

Behaviour:
- Reset (rst_n low at a clk edge), from any state and mid-operation:
  - state=IDLE.
  - busy, frame_done, rstMBT, start, wr_en = 0.
  - i_x, i_y, wr_addr, wr_data = 0; zoom_level = 0.
  - Sticky done and captured iteration registers are cleared.
  - No write is issued after reset.
- States and transitions:
  - IDLE: on frame_start=1, latch zoom_in into zoom_level and set x=0, y=0, base=0 -> RST. frame_start in any other state is ignored.
  - RST (1 cycle): rstMBT=1; i_x/i_y carry the tile coordinates. Clear sticky done bits -> SETTLE.
  - SETTLE (SETTLE_CYC cycles, down-counter): rstMBT=0 -> START.
  - START (1 cycle): start=1. mbt_done is ignored in this cycle (stale) -> WAIT.
  - WAIT: each cycle, for every lane k with mbt_done[k]=1 and sticky bit k clear:
    - set sticky bit k;
    - capture lane k of mbt_iter.
    - Later done pulses on an already-captured lane do not re-capture.
    - When all LANES sticky bits are set (including bits set in the current cycle) -> WRITE on the next edge. No timeout.
  - WRITE (LANES cycles, lane index 0..LANES-1): wr_en=1, wr_addr=base+lane, wr_data=captured[lane]. After lane LANES-1 -> ADV.
  - ADV (1 cycle):
    - base += LANES.
    - If x == H_RES-LANES: x=0, y+=1; else x += LANES.
    - If the finished tile was x==H_RES-LANES and y==V_RES-1 -> DONE; else -> RST.
  - DONE (1 cycle): frame_done=1 -> IDLE. x, y and base reset to 0 on the next frame_start.
- Timing and signal rules:
  - i_x and i_y are registered and stable from RST through WRITE, changing only on exit from ADV.
  - zoom_level is constant for the whole frame; zoom_in changes mid-frame have no effect.
  - Address generation is incremental (base register); no multiplier.
  - wr_addr wraps nowhere: its final value is H_RES*V_RES-1.
- Latency:
  - frame_start sampled at edge 0 -> rstMBT high in cycle 1 -> start high in cycle 2+SETTLE_CYC.
  - Per tile, minimum loop = 1 (RST) + SETTLE_CYC + 1 (START) + W (WAIT cycles) + LANES (WRITE) + 1 (ADV).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with frame_start=1 -> all outputs 0 and busy=0. Release -> still IDLE until the next frame_start.
- Small frame (H_RES=8, V_RES=2, LANES=4, SETTLE_CYC=2), cores return done 5 cycles after start with iter=lane+10*tile:
  - exactly 16 writes, addresses 0..15 in order;
  - data at addr 5 = 11;
  - i_x sequence 0,4,0,4 and i_y sequence 0,0,1,1;
  - frame_done pulses once, after the write to addr 15;
  - first start at cycle 4 after frame_start.
- Staggered completion: lane 2 done at +1, lane 0 at +3, lane 3 at +7, lane 1 at +9, with lane 0 re-pulsing later carrying a different count -> WRITE begins the cycle after +9, and lane 0 keeps its first-captured count.
- frame_start pulsed during WAIT with zoom_in=3 (frame started with 1) -> ignored; zoom_level stays 1 and the address sequence is unaffected.
- rst_n low for one cycle during WAIT of tile 2 -> IDLE, no further wr_en. A new frame_start restarts at addr 0 with i_x=0, i_y=0.
- mbt_done held high from before START -> not counted during START. Counted from the first WAIT cycle, so WRITE begins exactly 1 cycle after WAIT entry.

Source files
------------

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: frame-level sequencer for a bank of LANES Mandelbrot
// iteration cores. It walks the screen tile by tile in row-major order, where
// one tile is LANES horizontally adjacent pixels. For each tile it resets and
// starts the cores, gathers every lane's iteration count and then writes the
// counts to the frame buffer one pixel per cycle.
module pixel_scheduler #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int LANES      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int ITER_W     = 8,
  parameter int ADDR_W     = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [1:0]                zoom_in,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               i_x,
  output logic [15:0]               i_y,
  output logic [1:0]                zoom_level,
  output logic                      rstMBT,
  output logic                      start,
  input  logic [LANES-1:0]          mbt_done,
  input  logic [LANES*ITER_W-1:0]   mbt_iter,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [ITER_W-1:0]         wr_data
);

  // Width of the lane index and of the settle down-counter. Both are kept at
  // least one bit wide so the degenerate LANES=1 / SETTLE_CYC<=1 builds work.
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // Tile geometry constants, sized to the registers they are compared with.
  localparam logic [15:0]       X_LAST      = 16'(H_RES - LANES);
  localparam logic [15:0]       Y_LAST      = 16'(V_RES - 1);
  localparam logic [15:0]       X_STEP      = 16'(LANES);
  localparam logic [ADDR_W-1:0] A_STEP      = ADDR_W'(LANES);
  localparam logic [LW-1:0]     LANE_LAST   = LW'(LANES - 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_WRITE  = 3'd5,
    S_ADV    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // Control state.
  state_t              state_r;
  state_t              state_s;

  // Tile position. x_r/y_r drive i_x/i_y directly, so they only move when
  // ADV hands over to the next tile.
  logic [15:0]         x_r;
  logic [15:0]         x_s;
  logic [15:0]         y_r;
  logic [15:0]         y_s;

  // Linear address of lane 0 of the current tile. It is stepped by LANES
  // per tile, so y*H_RES + x is never computed with a multiplier.
  logic [ADDR_W-1:0]   base_r;
  logic [ADDR_W-1:0]   base_s;

  logic [LW-1:0]       lane_r;
  logic [LW-1:0]       lane_s;
  logic [SW-1:0]       settle_r;
  logic [SW-1:0]       settle_s;
  logic [1:0]          zoom_r;
  logic [1:0]          zoom_s;

  // Per-lane "already finished" flags and the counts captured with them.
  logic [LANES-1:0]    sticky_r;
  logic [LANES-1:0]    sticky_s;
  logic [ITER_W-1:0]   cap_r [LANES];
  logic [ITER_W-1:0]   cap_s [LANES];

  // Registered output copies.
  logic                busy_r;
  logic                frame_done_r;
  logic                rst_mbt_r;
  logic                start_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [ITER_W-1:0]   wr_data_r;

  // Next-state, tile-walk and capture logic; everything holds by default.
  always_comb begin
    state_s  = state_r;
    x_s      = x_r;
    y_s      = y_r;
    base_s   = base_r;
    lane_s   = lane_r;
    settle_s = settle_r;
    zoom_s   = zoom_r;
    sticky_s = sticky_r;
    cap_s    = cap_r;

    case (state_r)
      S_IDLE: begin
        if (frame_start) begin
          zoom_s  = zoom_in;
          x_s     = 16'd0;
          y_s     = 16'd0;
          base_s  = '0;
          state_s = S_RST;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_RST: begin
        sticky_s = '0;
        settle_s = SETTLE_LOAD;
        if (SETTLE_CYC == 0) begin
          state_s = S_START;
        end else begin
          state_s = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_r == '0) begin
          state_s = S_START;
        end else begin
          settle_s = settle_r - SW'(1'b1);
          state_s  = S_SETTLE;
        end
      end

      // The cores may still be showing done from the previous tile here, so
      // mbt_done is deliberately not looked at in this state.
      S_START: begin
        state_s = S_WAIT;
      end

      // A lane's count is taken only on its first done; later pulses on the
      // same lane are ignored. Bits set this cycle count towards "all done".
      S_WAIT: begin
        for (int k = 0; k < LANES; k++) begin
          if (mbt_done[k] && !sticky_r[k]) begin
            sticky_s[k] = 1'b1;
            cap_s[k]    = mbt_iter[k*ITER_W +: ITER_W];
          end else begin
            sticky_s[k] = sticky_r[k];
          end
        end
        if (&sticky_s) begin
          lane_s  = '0;
          state_s = S_WRITE;
        end else begin
          state_s = S_WAIT;
        end
      end

      S_WRITE: begin
        if (lane_r == LANE_LAST) begin
          state_s = S_ADV;
        end else begin
          lane_s  = lane_r + LW'(1'b1);
          state_s = S_WRITE;
        end
      end

      S_ADV: begin
        base_s = base_r + A_STEP;
        if (x_r == X_LAST) begin
          x_s = 16'd0;
          y_s = y_r + 16'd1;
        end else begin
          x_s = x_r + X_STEP;
          y_s = y_r;
        end
        if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RST;
        end
      end

      S_DONE: begin
        state_s = S_IDLE;
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers. Outputs are decoded from the next
  // state so that each strobe is high exactly while its state is current.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      x_r          <= 16'd0;
      y_r          <= 16'd0;
      base_r       <= '0;
      lane_r       <= '0;
      settle_r     <= '0;
      zoom_r       <= 2'd0;
      sticky_r     <= '0;
      for (int k = 0; k < LANES; k++) begin
        cap_r[k] <= '0;
      end
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      rst_mbt_r    <= 1'b0;
      start_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
    end else begin
      state_r      <= state_s;
      x_r          <= x_s;
      y_r          <= y_s;
      base_r       <= base_s;
      lane_r       <= lane_s;
      settle_r     <= settle_s;
      zoom_r       <= zoom_s;
      sticky_r     <= sticky_s;
      cap_r        <= cap_s;
      busy_r       <= (state_s != S_IDLE);
      frame_done_r <= (state_s == S_DONE);
      rst_mbt_r    <= (state_s == S_RST);
      start_r      <= (state_s == S_START);
      wr_en_r      <= (state_s == S_WRITE);
      if (state_s == S_WRITE) begin
        // cap_s is used so a lane captured on the last WAIT cycle is
        // already visible to the first write.
        wr_addr_r <= base_r + ADDR_W'(lane_s);
        wr_data_r <= cap_s[lane_s];
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign i_x        = x_r;
  assign i_y        = y_r;
  assign zoom_level = zoom_r;
  assign rstMBT     = rst_mbt_r;
  assign start      = start_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed bench for pixel_scheduler on an 8x2 screen
// with 4 lanes. A behavioural core bank answers each start pulse according
// to the selected mode; a monitor records writes, starts and frame_done.
module tb_pixel_scheduler;

  localparam int H  = 8;
  localparam int V  = 2;
  localparam int L  = 4;
  localparam int SC = 2;
  localparam int IW = 8;
  localparam int AW = 19;

  localparam int P_SX = 0;
  localparam int P_SY = 1;
  localparam int P_SC = 2;
  localparam int P_WA = 3;
  localparam int P_WD = 4;
  localparam int P_WC = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_start;
  logic [1:0]      zoom_in;
  logic            busy;
  logic            frame_done;
  logic [15:0]     i_x;
  logic [15:0]     i_y;
  logic [1:0]      zoom_level;
  logic            rstMBT;
  logic            start;
  logic [L-1:0]    mbt_done;
  logic [L*IW-1:0] mbt_iter;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [IW-1:0]   wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 0;

  int wa[$];
  int wd[$];
  int wc[$];
  int sc_q[$];
  int sx[$];
  int sy[$];
  int fd_cnt = 0;
  int fd_cyc = 0;

  pixel_scheduler #(
    .H_RES(H), .V_RES(V), .LANES(L), .SETTLE_CYC(SC), .ITER_W(IW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .zoom_in(zoom_in),
    .busy(busy), .frame_done(frame_done), .i_x(i_x), .i_y(i_y),
    .zoom_level(zoom_level), .rstMBT(rstMBT), .start(start),
    .mbt_done(mbt_done), .mbt_iter(mbt_iter), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp monitored events.
  always @(posedge clk) cyc <= cyc + 1;

  // Core bank model plus output monitor, both on the falling edge.
  initial begin
    int cnt;
    int tile;
    bit act;
    cnt  = 0;
    tile = 0;
    act  = 1'b0;
    mbt_done = '0;
    mbt_iter = '0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        act  = 1'b1;
        cnt  = 0;
        tile = int'(i_y) * (H / L) + int'(i_x) / L;
        sc_q.push_back(cyc);
        sx.push_back(int'(i_x));
        sy.push_back(int'(i_y));
      end else if (act) begin
        cnt++;
        if (cnt > 12) act = 1'b0;
      end
      if (wr_en === 1'b1) begin
        wa.push_back(int'(wr_addr));
        wd.push_back(int'(wr_data));
        wc.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      for (int k = 0; k < L; k++) begin
        automatic int   val = k + 10 * tile;
        automatic logic d   = 1'b0;
        case (mode)
          0: d = act && (cnt == 5);
          1: begin
            case (k)
              0: begin
                d = act && ((cnt == 3) || (cnt == 8));
                if (cnt == 8) val = 77;
              end
              1: d = act && (cnt == 9);
              2: d = act && (cnt == 1);
              default: d = act && (cnt == 7);
            endcase
          end
          default: begin
            d   = 1'b1;
            val = 64 + k;
          end
        endcase
        mbt_done[k] = d;
        mbt_iter[k*IW +: IW] = IW'(val);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pick(input int which, input int idx);
    int r;
    r = -1;
    case (which)
      P_SX: if (idx < sx.size())   r = sx[idx];
      P_SY: if (idx < sy.size())   r = sy[idx];
      P_SC: if (idx < sc_q.size()) r = sc_q[idx];
      P_WA: if (idx < wa.size())   r = wa[idx];
      P_WD: if (idx < wd.size())   r = wd[idx];
      default: if (idx < wc.size()) r = wc[idx];
    endcase
    return r;
  endfunction

  function automatic int data_at(input int from, input int addr);
    for (int i = from; i < wa.size(); i++) begin
      if (wa[i] == addr) return wd[i];
    end
    return -1;
  endfunction

  function automatic int order_errors(input int from);
    int bad;
    bad = 0;
    for (int i = from; i < wa.size(); i++) begin
      if (wa[i] != i - from) bad++;
    end
    return bad;
  endfunction

  task automatic launch(input logic [1:0] z, output int c);
    @(negedge clk);
    frame_start = 1'b1;
    zoom_in     = z;
    c           = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int got;
    got = 0;
    for (int i = 0; i < 600 && got == 0; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1;
    end
    check(tag, got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge clk);
      if (start === 1'b1) seen++;
    end
    check(tag, seen, n);
  endtask

  // Directed test sequence.
  initial begin
    int c;
    int w0;
    int s0;
    int f0;

    rst_n       = 1'b0;
    frame_start = 1'b1;
    zoom_in     = 2'd2;

    // Reset held with frame_start asserted.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_rstmbt", rstMBT, 0);
    check("rst_start", start, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ix", i_x, 0);
    check("rst_iy", i_y, 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", wr_data, 0);
    check("rst_zoom", zoom_level, 0);
    rst_n       = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rstmbt", rstMBT, 0);

    // Full small frame, uniform completion 5 cycles after start.
    mode = 0; w0 = wa.size(); s0 = sc_q.size(); f0 = fd_cnt;
    launch(2'd1, c);
    wait_frame("t2_frame_done");
    check("t2_nwrites", wa.size() - w0, 16);
    check("t2_addr_order", order_errors(w0), 0);
    check("t2_data5", data_at(w0, 5), 11);
    check("t2_data14", data_at(w0, 14), 32);
    for (int t = 0; t < 4; t++) begin
      check("t2_ix", pick(P_SX, s0 + t), (t % 2) * 4);
      check("t2_iy", pick(P_SY, s0 + t), t / 2);
    end
    check("t2_fd_count", fd_cnt - f0, 1);
    check("t2_fd_after_last", fd_cyc - pick(P_WC, w0 + 15), 2);
    check("t2_first_start", pick(P_SC, s0) - c, 4);
    check("t2_zoom", zoom_level, 1);
    check("t2_busy_end", busy, 0);

    // Staggered completion with a late re-pulse on lane 0.
    mode = 1; w0 = wa.size(); s0 = sc_q.size();
    launch(2'd1, c);
    wait_frame("t3_frame_done");
    check("t3_nwrites", wa.size() - w0, 16);
    check("t3_write_lat", pick(P_WC, w0) - pick(P_SC, s0), 10);
    check("t3_lane0", data_at(w0, 0), 0);
    check("t3_lane1", data_at(w0, 1), 1);
    check("t3_lane2", data_at(w0, 2), 2);
    check("t3_lane3", data_at(w0, 3), 3);
    check("t3_lane0_t1", data_at(w0, 4), 10);

    // frame_start with a new zoom during WAIT is ignored.
    mode = 0; w0 = wa.size(); s0 = sc_q.size();
    launch(2'd1, c);
    wait_starts("t4_first_start", 1);
    @(negedge clk);
    frame_start = 1'b1;
    zoom_in     = 2'd3;
    @(negedge clk);
    frame_start = 1'b0;
    zoom_in     = 2'd0;
    check("t4_zoom_mid", zoom_level, 1);
    wait_frame("t4_frame_done");
    check("t4_nwrites", wa.size() - w0, 16);
    check("t4_addr_order", order_errors(w0), 0);
    check("t4_nstarts", sc_q.size() - s0, 4);
    check("t4_zoom_end", zoom_level, 1);

    // Reset pulse during WAIT of the third tile, then a clean restart.
    mode = 0; w0 = wa.size(); s0 = sc_q.size();
    launch(2'd2, c);
    wait_starts("t5_three_starts", 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_writes_before", wa.size() - w0, 8);
    check("t5_busy", busy, 0);
    check("t5_wr_en", wr_en, 0);
    check("t5_zoom", zoom_level, 0);
    w0 = wa.size(); s0 = sc_q.size();
    launch(2'd1, c);
    wait_frame("t5_frame_done");
    check("t5_first_addr", pick(P_WA, w0), 0);
    check("t5_first_ix", pick(P_SX, s0), 0);
    check("t5_first_iy", pick(P_SY, s0), 0);
    check("t5_nwrites", wa.size() - w0, 16);

    // mbt_done held high throughout: stale during START, counted in WAIT.
    mode = 2; w0 = wa.size(); s0 = sc_q.size();
    launch(2'd1, c);
    wait_frame("t6_frame_done");
    check("t6_write_lat", pick(P_WC, w0) - pick(P_SC, s0), 2);
    check("t6_data0", data_at(w0, 0), 64);
    check("t6_data13", data_at(w0, 13), 65);
    check("t6_nwrites", wa.size() - w0, 16);
    check("t6_last_addr", pick(P_WA, w0 + 15), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
